fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, PC step and the prefetch queue entry format for the fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch queue of fetch entries with push/pop/flush and head read-out.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [COUNT_W-1:0] r_count;
  fetch_entry_t       r_mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (i_push && !i_flush && !reset) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_full  = (r_count == COUNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, redirect handling and a prefetch queue to the consumer.
// Optional macro FETCH_UNIT_PERF_EN adds the io_stall_cycles counter output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [XLEN-1:0]   io_instmem_addr,
  input  logic [INST_W-1:0] io_instmem_inst,
  input  logic              io_redirect_valid,
  input  logic [XLEN-1:0]   io_redirect_pc,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [INST_W-1:0] io_out_inst,
`ifdef FETCH_UNIT_PERF_EN
  output logic [XLEN-1:0]   io_out_pc,
  output logic [31:0]       io_stall_cycles
`else
  output logic [XLEN-1:0]   io_out_pc
`endif
);

  logic [XLEN-1:0] r_fetch_pc;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

  // Redirect wins over both queue ports; a pop frees a slot for a same-cycle push.
  assign w_pop   = !w_empty && io_out_ready && !io_redirect_valid;
  assign w_push  = !io_redirect_valid && (!w_full || w_pop);
  assign w_wdata = '{pc: r_fetch_pc, inst: io_instmem_inst};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= START_ADDR;
    end else if (io_redirect_valid) begin
      r_fetch_pc <= {io_redirect_pc[XLEN-1:2], 2'b00};
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (io_redirect_valid),
    .i_wdata (w_wdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign io_instmem_addr = r_fetch_pc;
  assign io_out_valid    = !w_empty;
  assign io_out_inst     = w_head.inst;
  assign io_out_pc       = w_head.pc;

`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] r_stall_cycles;

  // Counts bubble cycles seen by the consumer, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_empty && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign io_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns the inverted address.
// Define FETCH_UNIT_PERF_EN to also check io_stall_cycles.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] instmem_addr;
  logic [31:0] instmem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(
    .START_ADDR (32'h0000_0000),
    .DEPTH      (4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .io_instmem_addr   (instmem_addr),
    .io_instmem_inst   (instmem_inst),
    .io_redirect_valid (redirect_valid),
    .io_redirect_pc    (redirect_pc),
    .io_out_valid      (out_valid),
    .io_out_ready      (out_ready),
    .io_out_inst       (out_inst),
`ifdef FETCH_UNIT_PERF_EN
    .io_out_pc         (out_pc),
    .io_stall_cycles   (stall_cycles)
`else
    .io_out_pc         (out_pc)
`endif
  );

  assign instmem_inst = ~instmem_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_addr", instmem_addr, 32'h0);
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_pc"}, out_pc, pc);
    check_eq({tag, "_inst"}, out_inst, ~pc);
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // Streaming after reset: bubble, then one instruction per cycle.
    do_reset();
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_head("stream", 32'(4 * i));
      tick();
    end

    // Back-pressure fills the queue, then drains with no gap.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check_head("full_hold", 32'h0);
    check_eq("full_addr", instmem_addr, 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_head("drain", 32'(4 * i));
      tick();
    end

    // Redirect with three entries queued; low address bits dropped.
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    check_eq("q3_addr", instmem_addr, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    check_eq("redir_bubble", 32'(out_valid), 32'd0);
    check_eq("redir_addr", instmem_addr, 32'h100);
    tick();
    check_head("redir_first", 32'h100);

    // Redirect near the top of memory; PC wraps through zero.
    out_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_bubble", 32'(out_valid), 32'd0);
    tick();
    check_head("wrap0", 32'hFFFF_FFF8);
    tick();
    check_head("wrap1", 32'hFFFF_FFFC);
    tick();
    check_head("wrap2", 32'h0000_0000);
    tick();
    check_head("wrap3", 32'h0000_0004);

    // Reset beats a concurrent redirect on a full queue.
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    tick();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    check_eq("rst_redir_valid", 32'(out_valid), 32'd0);
    check_eq("rst_redir_addr", instmem_addr, 32'h0);
    tick();
    check_head("rst_redir_first", 32'h0);

`ifdef FETCH_UNIT_PERF_EN
    // One stall after reset, one per redirect.
    out_ready = 1'b1;
    do_reset();
    tick();
    tick();
    check_eq("stall_boot", stall_cycles, 32'd1);
    for (int r = 0; r < 2; r++) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
    end
    check_eq("stall_redir", stall_cycles, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
